chan_scan_ser14: RTL and testbench

Round-robin channel scanner and serial-DAC driver that sits directly downstream of the 4 x 14-bit sample multiplexer. It drives the multiplexer's 2-bit select and captures the selected 14-bit sample. It then shifts the sample, tagged with its channel number, to a 16-bit serial DAC/codec over a SCLK/SDO/SYNCN interface. Channels are serviced in strict round-robin order under an enable mask.

---
 rtl/chan_scan_ser14.sv | 138 +++++++++++++
 tb/tb_chan_scan_ser14.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_ser14.sv
// Round-robin scanner for a 4 x 14-bit sample mux. Each selected sample is
// sent to a 16-bit serial DAC as {channel, sample}, MSB first.
module chan_scan_ser14 #(
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        EN,
  input  logic [3:0]  MASK,
  output logic [1:0]  S,
  input  logic [13:0] Y,
  output logic        SCLK,
  output logic        SDO,
  output logic        SYNCN,
  output logic [1:0]  CH,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP);

  state_t      state, state_nxt;
  logic [1:0]  last_ch, next_ch, cand;
  logic        found;
  logic [7:0]  div_cnt, gap_cnt;
  logic [4:0]  half_cnt;
  logic [14:0] shreg;

  logic can_start, div_tick, gap_done;
  logic start_frame, stop_scan, sclk_rise, sclk_fall, frame_end;

  // First enabled channel after the last one served, wrapping back to it.
  always_comb begin
    next_ch = last_ch;
    found   = 1'b0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ch + 2'(i);
      if (!found && MASK[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  assign can_start = EN && (MASK != 4'b0000);
  assign div_tick  = (div_cnt == DIV_LAST);
  assign gap_done  = (gap_cnt == GAP_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (can_start) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SHIFT;
      ST_SHIFT:  if (frame_end) state_nxt = ST_GAP;
      ST_GAP:    if (gap_done) state_nxt = can_start ? ST_SETTLE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The last GAP cycle doubles as the decision cycle for the next frame.
  always_comb begin
    start_frame = ((state == ST_IDLE) || (state == ST_GAP && gap_done)) && can_start;
    stop_scan   = (state == ST_GAP) && gap_done && !can_start;
    sclk_rise   = (state == ST_SHIFT) && div_tick && !half_cnt[0];
    sclk_fall   = (state == ST_SHIFT) && div_tick && half_cnt[0];
    frame_end   = sclk_fall && (half_cnt == 5'd31);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      S        <= 2'd0;
      SCLK     <= 1'b0;
      SDO      <= 1'b0;
      SYNCN    <= 1'b1;
      CH       <= 2'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      last_ch  <= 2'd3;
      div_cnt  <= 8'd0;
      gap_cnt  <= 8'd0;
      half_cnt <= 5'd0;
      shreg    <= 15'd0;
    end else begin
      DONE <= 1'b0;
      if (start_frame) begin
        S    <= next_ch;
        BUSY <= 1'b1;
      end else if (stop_scan) begin
        BUSY <= 1'b0;
      end
      if (state == ST_LOAD) begin
        shreg    <= {S[0], Y};
        CH       <= S;
        last_ch  <= S;
        SDO      <= S[1];
        SYNCN    <= 1'b0;
        div_cnt  <= 8'd0;
        half_cnt <= 5'd0;
      end
      if (state == ST_SHIFT) begin
        div_cnt <= div_tick ? 8'd0 : div_cnt + 8'd1;
        if (div_tick) half_cnt <= half_cnt + 5'd1;
      end
      if (sclk_rise) SCLK <= 1'b1;
      // Data advances on the falling edge so it is stable around each rise.
      if (sclk_fall) begin
        SCLK  <= 1'b0;
        SDO   <= shreg[14];
        shreg <= {shreg[13:0], 1'b0};
      end
      if (frame_end) begin
        SYNCN   <= 1'b1;
        SDO     <= 1'b0;
        DONE    <= 1'b1;
        gap_cnt <= 8'd0;
      end
      if (state == ST_GAP && !gap_done) gap_cnt <= gap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_chan_scan_ser14.sv
// Bench for chan_scan_ser14: a DIV=4 scanner fed by a modelled mux, plus a
// DIV=1 instance whose Y input toggles after capture.
module tb_chan_scan_ser14;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        EN;
  logic [3:0]  MASK;
  logic [1:0]  S;
  logic [13:0] Y;
  logic        SCLK, SDO, SYNCN, BUSY, DONE;
  logic [1:0]  CH;

  logic        en1;
  logic [3:0]  mask1;
  logic [1:0]  s1;
  logic [13:0] y1 = 14'h0F0F;
  logic        sclk1, sdo1, syncn1, busy1, done1;
  logic [1:0]  ch1;

  logic [13:0] d_tab [4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  int          done_q[$];
  logic [1:0]  done_ch_q[$];

  logic        prev_sclk = 1'b0, prev_syncn = 1'b1;
  logic [15:0] word = 16'd0;
  int          bits = 0, low_cnt = 0, chg = 0, sclk_edges = 0;
  logic        abort0 = 1'b0;

  logic        prev_sclk1 = 1'b0, prev_syncn1 = 1'b1;
  logic [15:0] word1 = 16'd0;
  int          bits1 = 0, low_cnt1 = 0, chg1 = 0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs [5];

  always #5 CLK = ~CLK;

  assign Y = d_tab[S];

  chan_scan_ser14 #(.DIV(4), .GAP(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .MASK(MASK), .S(S), .Y(Y),
    .SCLK(SCLK), .SDO(SDO), .SYNCN(SYNCN), .CH(CH), .BUSY(BUSY), .DONE(DONE)
  );

  chan_scan_ser14 #(.DIV(1), .GAP(2)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .EN(en1), .MASK(mask1), .S(s1), .Y(y1),
    .SCLK(sclk1), .SDO(sdo1), .SYNCN(syncn1), .CH(ch1), .BUSY(busy1), .DONE(done1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic en, input logic [3:0] mask);
    @(negedge CLK);
    RSTN = rstn;
    EN   = en;
    MASK = mask;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 4'b0000);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 4'b0000);
  endtask

  task automatic waitDrain(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? exp_q.size() : exp1_q.size()) != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain_timeout", (which == 0) ? exp_q.size() : exp1_q.size(), 0);
  endtask

  function automatic logic [15:0] wordFor(input logic [1:0] c);
    return {c, d_tab[c]};
  endfunction

  // Frame monitor for the DIV=4 instance: rebuilds each word from SCLK rises.
  always @(negedge CLK) begin
    cyc++;
    if (DONE) begin
      done_q.push_back(cyc);
      done_ch_q.push_back(CH);
    end
    if (SCLK != prev_sclk) sclk_edges++;
    if (!SYNCN) begin
      if (prev_syncn) begin
        bits = 0; word = 16'd0; low_cnt = 0; chg = 0;
      end
      low_cnt++;
    end
    if (!prev_syncn && SCLK != prev_sclk) chg++;
    if (!SYNCN && SCLK && !prev_sclk) begin
      word = {word[14:0], SDO};
      bits++;
    end
    if (SYNCN && !prev_syncn) begin
      if (abort0) begin
        abort0 = 1'b0;
      end else begin
        checkOutput("syncn_low_cycles", low_cnt, 128);
        checkOutput("bits_per_frame", bits, 16);
        checkOutput("sclk_edges_per_frame", chg, 32);
        checkOutput("done_at_frame_end", {31'd0, DONE}, 1);
        if (exp_q.size() == 0) checkOutput("unexpected_frame", word, 32'hFFFF_FFFF);
        else checkOutput("frame_word", word, exp_q.pop_front());
      end
    end
    prev_sclk  = SCLK;
    prev_syncn = SYNCN;
  end

  // Monitor for the DIV=1 instance; Y toggles every cycle once the word is loaded.
  always @(negedge CLK) begin
    if (!syncn1) begin
      if (prev_syncn1) begin
        bits1 = 0; word1 = 16'd0; low_cnt1 = 0; chg1 = 0;
      end
      low_cnt1++;
      y1 = y1 ^ 14'h3FFF;
    end else begin
      y1 = 14'h0F0F;
    end
    if (!prev_syncn1 && sclk1 != prev_sclk1) chg1++;
    if (!syncn1 && sclk1 && !prev_sclk1) begin
      word1 = {word1[14:0], sdo1};
      bits1++;
    end
    if (syncn1 && !prev_syncn1) begin
      checkOutput("div1_frame_cycles", low_cnt1, 32);
      checkOutput("div1_bits", bits1, 16);
      checkOutput("div1_sclk_every_cycle", chg1, 32);
      checkOutput("div1_done", {31'd0, done1}, 1);
      if (exp1_q.size() == 0) checkOutput("div1_unexpected_frame", word1, 32'hFFFF_FFFF);
      else checkOutput("div1_word", word1, exp1_q.pop_front());
    end
    prev_sclk1  = sclk1;
    prev_syncn1 = syncn1;
  end

  initial begin
    int n;
    int e0;
    int viol;
    int nd;
    logic [1:0] c;

    RSTN = 1'b0; EN = 1'b0; MASK = 4'b0000;
    en1 = 1'b0; mask1 = 4'b0000;
    d_tab[0] = 14'h0001; d_tab[1] = 14'h1555; d_tab[2] = 14'h2AAA; d_tab[3] = 14'h3FFF;

    vecs[0] = '{mask: 4'b1111, seq: {2'd0, 2'd1, 2'd2, 2'd3}};
    vecs[1] = '{mask: 4'b1010, seq: {2'd1, 2'd3, 2'd1, 2'd3}};
    vecs[2] = '{mask: 4'b0100, seq: {2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[3] = '{mask: 4'b1001, seq: {2'd0, 2'd3, 2'd0, 2'd3}};
    vecs[4] = '{mask: 4'b0110, seq: {2'd1, 2'd2, 2'd1, 2'd2}};

    doReset();
    @(negedge CLK);
    checkOutput("reset_S", S, 0);
    checkOutput("reset_SCLK", SCLK, 0);
    checkOutput("reset_SDO", SDO, 0);
    checkOutput("reset_SYNCN", SYNCN, 1);
    checkOutput("reset_CH", CH, 0);
    checkOutput("reset_BUSY", BUSY, 0);
    checkOutput("reset_DONE", DONE, 0);

    // Continuous scans across mask patterns: four frames each.
    for (int v = 0; v < 5; v++) begin
      doReset();
      done_q.delete();
      done_ch_q.delete();
      for (int k = 0; k < 4; k++) begin
        c = vecs[v].seq[7 - 2*k -: 2];
        exp_q.push_back(wordFor(c));
      end
      applyStimulus(1'b1, 1'b1, vecs[v].mask);
      waitDrain(0, 1000);
      EN = 1'b0;
      repeat (200) @(negedge CLK);
      checkOutput("scan_busy_after_stop", BUSY, 0);
      checkOutput("scan_done_count", done_q.size(), 4);
      if (done_q.size() == 4) begin
        for (int k = 0; k < 4; k++)
          checkOutput("scan_ch", done_ch_q[k], vecs[v].seq[7 - 2*k -: 2]);
        for (int k = 1; k < 4; k++)
          checkOutput("done_spacing", done_q[k] - done_q[k-1], 133);
      end
    end

    // EN drops during bit 5 of channel 2; that frame still completes.
    doReset();
    done_q.delete();
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'hAAAA);
    applyStimulus(1'b1, 1'b1, 4'b1111);
    n = 0;
    while (!(CH == 2'd2 && !SYNCN && bits == 5) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("stop_reach_bit5_timeout", (n < 1000) ? 1 : 0, 1);
    EN = 1'b0;
    waitDrain(0, 400);
    repeat (5) @(negedge CLK);
    e0 = sclk_edges;
    repeat (300) @(negedge CLK);
    checkOutput("stop_busy", BUSY, 0);
    checkOutput("stop_no_sclk", sclk_edges - e0, 0);
    checkOutput("stop_done_count", done_q.size(), 3);

    // Reset pulse in the middle of channel 1's frame.
    doReset();
    exp_q.push_back(16'h0001);
    applyStimulus(1'b1, 1'b1, 4'b1111);
    waitDrain(0, 400);
    n = 0;
    while (!(CH == 2'd1 && !SYNCN && bits == 3) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("rst_reach_shift_timeout", (n < 400) ? 1 : 0, 1);
    nd = done_q.size();
    abort0 = 1'b1;
    RSTN = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_S", S, 0);
    checkOutput("midrst_SCLK", SCLK, 0);
    checkOutput("midrst_SDO", SDO, 0);
    checkOutput("midrst_SYNCN", SYNCN, 1);
    checkOutput("midrst_CH", CH, 0);
    checkOutput("midrst_BUSY", BUSY, 0);
    checkOutput("midrst_DONE", DONE, 0);
    RSTN = 1'b1;
    exp_q.push_back(16'h0001);
    waitDrain(0, 400);
    checkOutput("midrst_no_extra_done", done_q.size(), nd + 1);
    if (done_ch_q.size() > 0) checkOutput("midrst_first_ch", done_ch_q[done_ch_q.size()-1], 0);
    EN = 1'b0;
    repeat (200) @(negedge CLK);

    // Idle conditions: enabled with empty mask, then disabled with full mask.
    for (int k = 0; k < 2; k++) begin
      doReset();
      applyStimulus(1'b1, (k == 0) ? 1'b1 : 1'b0, (k == 0) ? 4'b0000 : 4'b1111);
      e0 = sclk_edges;
      viol = 0;
      repeat (1000) begin
        @(negedge CLK);
        if (!SYNCN || BUSY) viol++;
      end
      checkOutput("idle_no_sclk", sclk_edges - e0, 0);
      checkOutput("idle_syncn_busy", viol, 0);
    end

    // DIV=1 instance: single frame with Y changing after capture.
    doReset();
    exp1_q.push_back(16'h0F0F);
    mask1 = 4'b0001;
    en1 = 1'b1;
    n = 0;
    while (!busy1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("div1_start_timeout", busy1, 1);
    en1 = 1'b0;
    waitDrain(1, 200);
    repeat (20) @(negedge CLK);
    checkOutput("div1_busy_after", busy1, 0);
    checkOutput("div1_ch", ch1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
